// File: rtl/branch_redirect_ctrl.sv
// Branch resolution controller: 2-bit BHT prediction, mispredict detection,
// and PC redirect handshake followed by a timed pipeline flush.
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [2:0]      ex_br_type,
    input  logic            ex_br_taken,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [15:0]     branch_cnt,
    output logic [15:0]     mispred_cnt
);
    localparam int IDX = $clog2(BHT_ENTRIES);
    localparam int CW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the valid side holds its payload stable until that edge.
    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      bht [BHT_ENTRIES];
    logic            accept, is_branch, is_cond, eff_taken, mispredict;
    logic [XLEN-1:0] corrected_pc;
    logic [IDX-1:0]  ex_idx;
    logic            unused_if_pc;

    assign if_pred_taken = bht[if_pc[IDX+1:2]][1];
    assign unused_if_pc  = ^{if_pc[XLEN-1:IDX+2], if_pc[1:0]};

    always_comb begin
        ex_idx       = ex_pc[IDX+1:2];
        accept       = ex_valid & ex_ready;
        is_branch    = (ex_br_type != 3'b000);
        is_cond      = is_branch & (ex_br_type != 3'b111);
        // Unconditional jumps always resolve taken, whatever the comparator says.
        eff_taken    = (ex_br_type == 3'b111) | ex_br_taken;
        mispredict   = accept & is_branch & (eff_taken != ex_pred_taken);
        corrected_pc = eff_taken ? ex_target : ex_pc + XLEN'(4);
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        ex_ready       = 1'b0;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        case (state)
            IDLE: begin
                ex_ready = 1'b1;
                if (mispredict) state_nxt = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                if (redirect_ready) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = CW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (accept && is_branch) begin
            if (branch_cnt != 16'hFFFF) branch_cnt <= branch_cnt + 16'd1;
            if (mispredict) begin
                redirect_pc <= corrected_pc;
                if (mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
            end
        end
    end

    // Weakly not-taken after reset so every lookup predicts not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (accept && is_cond) begin
            if (ex_br_taken) begin
                if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
            end else begin
                if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
            end
        end
    end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: BHT reference model, counter model
// and an expected-redirect queue compared at each redirect handshake.
module tb_branch_redirect_ctrl;
    localparam int FLUSH_CYCLES = 2;

    logic        clk, rst_n;
    logic [31:0] if_pc, ex_pc, ex_target, redirect_pc;
    logic        if_pred_taken, ex_valid, ex_ready, ex_br_taken, ex_pred_taken;
    logic [2:0]  ex_br_type;
    logic        redirect_valid, redirect_ready, flush;
    logic [15:0] branch_cnt, mispred_cnt;

    logic [31:0] exp_q[$];
    logic [1:0]  bht_m [16];
    logic [15:0] br_m, mp_m;
    int          passed, total;

    branch_redirect_ctrl #(.XLEN(32), .BHT_ENTRIES(16), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_br_type(ex_br_type),
        .ex_br_taken(ex_br_taken), .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
        .ex_target(ex_target), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .flush(flush),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
        br_m = '0;
        mp_m = '0;
        exp_q.delete();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_branch_cnt"}, {16'h0, branch_cnt}, {16'h0, br_m});
        check({tag, "_mispred_cnt"}, {16'h0, mispred_cnt}, {16'h0, mp_m});
    endtask

    // Present one resolution for one cycle; the model updates as of the accept edge.
    task automatic send(input logic [2:0] t, input logic tk, input logic pd,
                        input logic [31:0] pc, input logic [31:0] tg);
        logic       eff;
        logic [3:0] ix;
        ix  = pc[5:2];
        eff = (t == 3'b111) ? 1'b1 : tk;
        if_pc = pc; ex_br_type = t; ex_br_taken = tk; ex_pred_taken = pd;
        ex_pc = pc; ex_target = tg; ex_valid = 1'b1;
        #1;
        check("ex_ready_idle", {31'h0, ex_ready}, 32'h1);
        check("pred_pre_update", {31'h0, if_pred_taken}, {31'h0, bht_m[ix][1]});
        step();
        ex_valid = 1'b0;
        if (t != 3'b000) begin
            if (br_m != 16'hFFFF) br_m++;
            if (eff != pd) begin
                if (mp_m != 16'hFFFF) mp_m++;
                exp_q.push_back(eff ? tg : pc + 32'd4);
            end
            if (t != 3'b111) begin
                if (tk && bht_m[ix] != 2'b11) bht_m[ix]++;
                else if (!tk && bht_m[ix] != 2'b00) bht_m[ix]--;
            end
        end
    endtask

    task automatic check_pred(input logic [31:0] pc, input string tag);
        if_pc = pc;
        #1;
        check(tag, {31'h0, if_pred_taken}, {31'h0, bht_m[pc[5:2]][1]});
    endtask

    // Hold redirect_ready low for 'delay' cycles (optionally poking ex_valid),
    // then complete the handshake and walk the flush tail.
    task automatic redirect_seq(input int delay, input logic poke);
        logic [31:0] exp_pc;
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL redirect_queue: observed empty expected entry");
            exp_pc = 32'h0;
        end else exp_pc = exp_q[0];
        for (int i = 0; i < delay; i++) begin
            check("wait_redirect_valid", {31'h0, redirect_valid}, 32'h1);
            check("wait_flush", {31'h0, flush}, 32'h1);
            check("wait_ex_ready", {31'h0, ex_ready}, 32'h0);
            check("wait_redirect_pc", redirect_pc, exp_pc);
            if (poke) begin
                ex_valid = 1'b1; ex_br_type = 3'b001; ex_br_taken = 1'b1;
                ex_pred_taken = 1'b0; ex_pc = 32'h0000_0050; ex_target = 32'hDEAD_0000;
            end
            step();
            ex_valid = 1'b0;
        end
        redirect_ready = 1'b1;
        #1;
        check("hs_redirect_valid", {31'h0, redirect_valid}, 32'h1);
        check("hs_flush", {31'h0, flush}, 32'h1);
        check("hs_ex_ready", {31'h0, ex_ready}, 32'h0);
        check("hs_redirect_pc", redirect_pc, exp_pc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        step();
        redirect_ready = 1'b0;
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            check("tail_flush", {31'h0, flush}, 32'h1);
            check("tail_redirect_valid", {31'h0, redirect_valid}, 32'h0);
            check("tail_ex_ready", {31'h0, ex_ready}, 32'h0);
            step();
        end
        check("post_flush", {31'h0, flush}, 32'h0);
        check("post_ex_ready", {31'h0, ex_ready}, 32'h1);
    endtask

    initial begin
        passed = 0; total = 0;
        rst_n = 1'b0; redirect_ready = 1'b0; ex_valid = 1'b0;
        if_pc = '0; ex_pc = '0; ex_target = '0; ex_br_type = '0;
        ex_br_taken = 1'b0; ex_pred_taken = 1'b0;
        model_reset();
        step(); step();

        // Reset state
        check("rst_redirect_valid", {31'h0, redirect_valid}, 32'h0);
        check("rst_flush", {31'h0, flush}, 32'h0);
        check("rst_ex_ready", {31'h0, ex_ready}, 32'h1);
        check_counts("rst");
        for (int i = 0; i < 16; i++) check_pred(32'(i * 4), "rst_pred");
        rst_n = 1'b1;
        step();

        // BHT training at 0x40 (entry 0)
        send(3'b001, 1'b1, 1'b1, 32'h40, 32'h200);
        send(3'b001, 1'b1, 1'b1, 32'h40, 32'h200);
        check("train_pred_taken", {31'h0, if_pred_taken}, 32'h1);
        for (int i = 0; i < 4; i++) send(3'b001, 1'b0, 1'b0, 32'h40, 32'h200);
        check_pred(32'h40, "train_pred_not_taken");
        send(3'b001, 1'b1, 1'b1, 32'h40, 32'h200);
        check_pred(32'h40, "sat_low_one_up");
        check("sat_low_literal", {31'h0, if_pred_taken}, 32'h0);
        check_counts("train");

        // Mispredict taken, immediate redirect_ready
        send(3'b001, 1'b1, 1'b0, 32'h88, 32'h100);
        redirect_seq(0, 1'b0);
        check_counts("mp_taken");

        // Mispredict not-taken with PC wrap and backpressure
        send(3'b010, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h200);
        redirect_seq(4, 1'b1);
        check_counts("mp_wrap");

        // JAL with stale comparator outcome; BHT entry must not move
        send(3'b111, 1'b0, 1'b0, 32'h44, 32'h300);
        redirect_seq(1, 1'b0);
        check_pred(32'h44, "jal_bht_unchanged");
        check_counts("jal");

        // Type 000 is transparent
        send(3'b000, 1'b1, 1'b0, 32'h48, 32'h400);
        check("none_no_redirect", {31'h0, redirect_valid}, 32'h0);
        check("none_ex_ready", {31'h0, ex_ready}, 32'h1);
        check_counts("none");

        // Random correctly-predicted conditional branches exercise the BHT
        for (int i = 0; i < 24; i++) begin
            logic [2:0] t;
            logic       tk;
            t  = 3'($urandom_range(1, 6));
            tk = 1'($urandom_range(0, 1));
            send(t, tk, tk, 32'h1000 + 32'($urandom_range(0, 3) * 4), 32'h0);
        end
        for (int i = 0; i < 4; i++) check_pred(32'h1000 + 32'(i * 4), "rand_pred");
        check_counts("rand");

        // Asynchronous reset in the middle of REDIRECT
        send(3'b011, 1'b1, 1'b0, 32'h4C, 32'h500);
        if_pc = 32'h40;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_redirect_valid", {31'h0, redirect_valid}, 32'h0);
        check("arst_flush", {31'h0, flush}, 32'h0);
        check("arst_ex_ready", {31'h0, ex_ready}, 32'h1);
        check("arst_redirect_pc", redirect_pc, 32'h0);
        check("arst_pred", {31'h0, if_pred_taken}, 32'h0);
        check_counts("arst");
        #10;
        rst_n = 1'b1;
        step(); step();
        check("post_arst_redirect_valid", {31'h0, redirect_valid}, 32'h0);
        check("post_arst_flush", {31'h0, flush}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
